// File: rtl/tpm_ip_slave_lite_s00_axi.sv
// AXI4-Lite slave register bank for the TPM IP control/data window.
// 128 x 32-bit R/W registers, word-indexed by byte address bits [8:2].
// Ports:
//   S_AXI_ACLK/S_AXI_ARESET : clock, async active-high reset
//   AW/W/B channels         : single outstanding write, byte strobes, OKAY
//   AR/R channels           : single outstanding read, registered RDATA, OKAY
module tpm_ip_slave_lite_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IDXW  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NREG  = 2 ** IDXW;
    localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;

    logic                          awready_q, awready_d;
    logic                          bvalid_q, bvalid_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NREG];

    logic            wr_fire;
    logic            rd_fire;
    logic [IDXW-1:0] widx;
    logic [IDXW-1:0] ridx;
    logic            unused_w;

    // AWREADY and WREADY are one shared pulse: both channels are taken together.
    assign wr_fire = awready_q & S_AXI_AWVALID & awready_q & S_AXI_WVALID;
    assign rd_fire = arready_q & S_AXI_ARVALID;
    assign widx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ridx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    assign unused_w = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        // Ready is a single-cycle pulse, blocked while a response is pending.
        if (!awready_q && !bvalid_q && S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_d = 1'b1;
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (!arready_q && !rvalid_q && S_AXI_ARVALID) begin
            arready_d = 1'b1;
        end
        // Sampling regs_q here yields the pre-write value on a same-cycle hit.
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[ridx];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    regs_q[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_tpm_ip_slave_lite_s00_axi.sv
// Bench for tpm_ip_slave_lite_s00_axi: directed cases plus random
// traffic checked against an array model of the register bank.
module tb_tpm_ip_slave_lite_s00_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [8:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    logic [31:0] model [128];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tpm_ip_slave_lite_s00_axi dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_wr(input logic [8:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] v;
        v = model[a[8:2]];
        for (int b = 0; b < 4; b++)
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        model[a[8:2]] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_aw(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!awready && n < 16);
    endtask

    task automatic axi_write(input logic [8:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit hold);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        awprot = 3'($urandom);
        wait_aw(n);
        check("aw_lat", n, 1);
        check("w_rdy", {31'b0, wready}, 1);
        tick();
        model_wr(a, d, s);
        check("aw_pulse", {31'b0, awready}, 0);
        check("b_valid", {31'b0, bvalid}, 1);
        check("b_resp", {30'b0, bresp}, 0);
        if (hold) begin
            tick();
            check("aw_hold", {31'b0, awready}, 0);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick();
        check("b_clr", {31'b0, bvalid}, 0);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [8:0] a);
        logic [31:0] e;
        int n;
        e = model[a[8:2]];
        araddr = a; arvalid = 1'b1;
        arprot = 3'($urandom);
        n = 0;
        do begin
            tick();
            n++;
        end while (!arready && n < 16);
        check("ar_lat", n, 1);
        tick();
        arvalid = 1'b0;
        check("r_valid", {31'b0, rvalid}, 1);
        check("r_data", rdata, e);
        check("r_resp", {30'b0, rresp}, 0);
        tick();
        check("r_stable", rdata, e);
        check("ar_idle", {31'b0, arready}, 0);
        rready = 1'b1;
        tick();
        check("r_clr", {31'b0, rvalid}, 0);
        rready = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] old;
        for (int i = 0; i < 128; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'b0, awready}, 0);
        check("rst_bvalid", {31'b0, bvalid}, 0);
        check("rst_arready", {31'b0, arready}, 0);
        check("rst_rvalid", {31'b0, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        tick();

        axi_read(9'h000);
        axi_read(9'h004);
        axi_read(9'h1FC);

        axi_write(9'h004, 32'hDEADBEEF, 4'hF, 1'b1);
        axi_read(9'h004);
        axi_write(9'h1FF, 32'h00000012, 4'hF, 1'b0);
        axi_read(9'h1FF);
        axi_read(9'h1FC);
        axi_read(9'h004);
        axi_write(9'h008, 32'h11223344, 4'hF, 1'b0);
        axi_write(9'h008, 32'hAABBCCDD, 4'h5, 1'b0);
        check("strb_model", model[2], 32'h11BB33DD);
        axi_read(9'h008);

        // BREADY held low while a second write is offered
        awaddr = 9'h00C; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_aw(n);
        check("bp_lat", n, 1);
        tick();
        model_wr(9'h00C, 32'hCAFEF00D, 4'hF);
        awaddr = 9'h010; wdata = 32'h55667788; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_awready", {31'b0, awready}, 0);
            check("bp_bvalid", {31'b0, bvalid}, 1);
        end
        bready = 1'b1;
        tick();
        check("bp_bclr", {31'b0, bvalid}, 0);
        check("bp_noacc", {31'b0, awready}, 0);
        bready = 1'b0;
        wait_aw(n);
        check("bp_lat2", n, 1);
        tick();
        model_wr(9'h010, 32'h55667788, 4'hF);
        check("bp_bvalid2", {31'b0, bvalid}, 1);
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(9'h00C);
        axi_read(9'h010);

        // Same-cycle read and write of one register returns the old value
        old = model[8];
        awaddr = 9'h020; wdata = 32'h0BADC0DE; wstrb = 4'hF;
        araddr = 9'h020;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        check("rw_awready", {31'b0, awready}, 1);
        check("rw_arready", {31'b0, arready}, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_bvalid", {31'b0, bvalid}, 1);
        check("rw_rvalid", {31'b0, rvalid}, 1);
        check("rw_old", rdata, old);
        model_wr(9'h020, 32'h0BADC0DE, 4'hF);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(9'h020);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0)
                axi_write(9'($urandom), $urandom, 4'($urandom),
                          1'($urandom));
            else
                axi_read(9'($urandom));
        end

        // Reset while a read response is pending
        araddr = 9'h004; arvalid = 1'b1;
        tick();
        tick();
        arvalid = 1'b0;
        check("ra_rvalid", {31'b0, rvalid}, 1);
        #2 rst = 1'b1;
        #1;
        check("ra_rvalid0", {31'b0, rvalid}, 0);
        check("ra_rdata0", rdata, 0);
        check("ra_aw0", {31'b0, awready}, 0);
        check("ra_ar0", {31'b0, arready}, 0);
        check("ra_b0", {31'b0, bvalid}, 0);
        for (int i = 0; i < 128; i++) model[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        axi_read(9'h004);
        axi_read(9'h1FF);
        axi_read(9'h008);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
